// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array output drain.
//   SA_P_W / SA_M_W : default result width and operand width (result = 2x operand)
//   drain_st_e      : drain FSM encoding (IDLE=0, DRAIN=1)
//   slot_idx()      : position of PE(r,c) on the flattened array result bus
package sa_pkg;

    localparam int SA_P_W = 16;
    localparam int SA_M_W = SA_P_W / 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_st_e;

    // PE(0,0) sits in the most significant slot of the array bus.
    function automatic int slot_idx(input int r, input int c, input int hpe, input int vpe);
        return hpe * vpe - 1 - (r * hpe + c);
    endfunction

endpackage

// File: rtl/sa_row_mux.sv
// Combinational row selector for the drain shadow register.
// Picks row `row` out of the flattened snapshot and re-orders it so that
// PE(row,c) lands in field c of row_data (column 0 in the LSBs).
// Optional feature macro: SA_DRAIN_RELU_EN -- negative fields read out as 0;
// the snapshot itself is never modified.
// Ports:
//   shadow   in  P_W*HPE*VPE  captured array results (array bus layout)
//   row      in  IDX_W        row number to present
//   row_data out P_W*HPE      selected row, PE(row,c) at [P_W*(c+1)-1:P_W*c]
module sa_row_mux
    import sa_pkg::*;
#(
    parameter int HPE   = 8,
    parameter int VPE   = 8,
    parameter int P_W   = SA_P_W,
    parameter int IDX_W = (VPE > 1) ? $clog2(VPE) : 1
) (
    input  logic [P_W*HPE*VPE-1:0] shadow,
    input  logic [IDX_W-1:0]       row,
    output logic [P_W*HPE-1:0]     row_data
);

    for (genvar c = 0; c < HPE; c++) begin : g_col
        logic [P_W-1:0] fld;

        // Every candidate slot is a constant part-select; the row compare
        // builds a one-hot style mux per column.
        always_comb begin
            fld = '0;
            for (int r = 0; r < VPE; r++) begin
                if (row == IDX_W'(r))
                    fld = shadow[P_W*slot_idx(r, c, HPE, VPE) +: P_W];
            end
        end

`ifdef SA_DRAIN_RELU_EN
        assign row_data[P_W*c +: P_W] = fld[P_W-1] ? '0 : fld;
`else
        assign row_data[P_W*c +: P_W] = fld;
`endif
    end

endmodule

// File: rtl/sa_output_drain.sv
// Output drain for the output-stationary systolic array.
// START (when idle) snapshots the whole result bus, pulses ARRAY_CLR so the
// array can start its next tile, then streams one row per ROW_VALID/ROW_READY
// handshake, finishing with a one-cycle DONE pulse.
// Optional feature macro: SA_DRAIN_RELU_EN (ReLU on the read path, see sa_row_mux).
// Ports:
//   CLK, RST   clock (rising edge), asynchronous active-low reset
//   Y_IN       array result bus, sampled only on the capture edge
//   START      snapshot + drain request, ignored while BUSY
//   ARRAY_CLR  one-cycle pulse right after capture
//   ROW_DATA   current row, ROW_IDX its row number, ROW_VALID qualifies both
//   ROW_READY  sink ready
//   BUSY       high while draining
//   DONE       one-cycle pulse after the last row is accepted
module sa_output_drain
    import sa_pkg::*;
#(
    parameter int HPE   = 8,
    parameter int VPE   = 8,
    parameter int P_W   = SA_P_W,
    parameter int IDX_W = (VPE > 1) ? $clog2(VPE) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [P_W*HPE*VPE-1:0] Y_IN,
    input  logic                   START,
    output logic                   ARRAY_CLR,
    output logic [P_W*HPE-1:0]     ROW_DATA,
    output logic [IDX_W-1:0]       ROW_IDX,
    output logic                   ROW_VALID,
    input  logic                   ROW_READY,
    output logic                   BUSY,
    output logic                   DONE
);

    drain_st_e              state;
    logic [P_W*HPE*VPE-1:0] shadow;

    // ROW_DATA is a pure function of the held snapshot and the registered row
    // index, so it is automatically stable under backpressure.
    sa_row_mux #(
        .HPE   (HPE),
        .VPE   (VPE),
        .P_W   (P_W),
        .IDX_W (IDX_W)
    ) u_row_mux (
        .shadow   (shadow),
        .row      (ROW_IDX),
        .row_data (ROW_DATA)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            shadow    <= '0;
            ROW_IDX   <= '0;
            ROW_VALID <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ARRAY_CLR <= 1'b0;
        end else begin
            DONE      <= 1'b0;
            ARRAY_CLR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state     <= ST_DRAIN;
                        shadow    <= Y_IN;
                        ROW_IDX   <= '0;
                        ROW_VALID <= 1'b1;
                        BUSY      <= 1'b1;
                        ARRAY_CLR <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // START is deliberately not looked at here: no re-capture, no queuing.
                    if (ROW_VALID && ROW_READY) begin
                        if (ROW_IDX == IDX_W'(VPE - 1)) begin
                            state     <= ST_IDLE;
                            ROW_IDX   <= '0;
                            ROW_VALID <= 1'b0;
                            BUSY      <= 1'b0;
                            DONE      <= 1'b1;
                        end else begin
                            ROW_IDX <= ROW_IDX + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
